// File: rtl/bin_cmd_seq.sv
// bin_cmd_seq: queued command sequencer that drives the control strobes of a
// binary up/down counter. Commands sit in a small FIFO and are executed by an
// IDLE/EXEC state machine. Back-to-back commands run with no idle gap.
//
//   state | meaning
//   IDLE  | no command executing; pops the FIFO head whenever level > 0
//   EXEC  | command active; rem holds the active cycles left, including this one
module bin_cmd_seq #(
    parameter int N     = 8,
    parameter int CW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [N-1:0]               cmd_data,
    input  logic [CW-1:0]              cmd_cycles,
    input  logic                       abort,
    output logic                       syn_clr,
    output logic                       load,
    output logic                       en,
    output logic                       up,
    output logic [N-1:0]               d,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [2:0] OP_UP   = 3'd1;
    localparam logic [2:0] OP_DN   = 3'd2;
    localparam logic [2:0] OP_LOAD = 3'd3;
    localparam logic [2:0] OP_SCLR = 3'd4;
    localparam logic [2:0] OP_WAIT = 3'd5;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t          state;
    logic [CW-1:0]   rem;
    logic [2:0]      mem_op   [DEPTH];
    logic [N-1:0]    mem_data [DEPTH];
    logic [CW-1:0]   mem_cyc  [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;
    logic            last;
    logic [2:0]      head_op;
    logic [N-1:0]    head_data;
    logic [CW-1:0]   head_cyc;

    // Handshake, pop decision and FIFO head view; reset input gates ready so it
    // reads low for the whole time reset is held.
    always_comb begin
        cmd_ready = reset && (level < DEPTH_L) && !abort;
        push      = cmd_valid && cmd_ready;
        last      = (state == EXEC) && (rem == CW'(1));
        pop       = !abort && (level != '0) && ((state == IDLE) || last);
        busy      = (state == EXEC) || (level != '0);
        head_op   = mem_op[rd_ptr];
        head_data = mem_data[rd_ptr];
        head_cyc  = mem_cyc[rd_ptr];
    end

    // FIFO storage; payload needs no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]   <= cmd_op;
            mem_data[wr_ptr] <= cmd_data;
            mem_cyc[wr_ptr]  <= cmd_cycles;
        end
    end

    // FIFO pointers and occupancy; abort flushes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
        end
    end

    // Sequencer: strobes and done are registered so they line up with the
    // active cycles; d only moves when a LOAD starts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rem     <= '0;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
        end else if (abort) begin
            state   <= IDLE;
            rem     <= '0;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            done    <= 1'b0;
        end else if (pop) begin
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            case (head_op)
                OP_UP, OP_DN, OP_WAIT: begin
                    if (head_cyc == '0) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= EXEC;
                        rem   <= head_cyc;
                        done  <= (head_cyc == CW'(1));
                        en    <= (head_op != OP_WAIT);
                        up    <= (head_op == OP_UP);
                    end
                end
                OP_LOAD: begin
                    state <= EXEC;
                    rem   <= CW'(1);
                    load  <= 1'b1;
                    d     <= head_data;
                    done  <= 1'b1;
                end
                OP_SCLR: begin
                    state   <= EXEC;
                    rem     <= CW'(1);
                    syn_clr <= 1'b1;
                    done    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            endcase
        end else if (last) begin
            state   <= IDLE;
            rem     <= '0;
            syn_clr <= 1'b0;
            load    <= 1'b0;
            en      <= 1'b0;
            up      <= 1'b0;
            done    <= 1'b0;
        end else if (state == EXEC) begin
            rem  <= rem - CW'(1);
            done <= (rem == CW'(2));
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin_cmd_seq.sv
// Directed bench for bin_cmd_seq: linear sequence of scenarios with
// hand-computed expectations checked by immediate assertions.
module tb_bin_cmd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_cycles;
    logic        abort;
    logic        syn_clr, load, en, up, busy, done;
    logic [7:0]  d;
    logic [2:0]  level;

    int n_assert = 0;
    int n_fail   = 0;

    logic [5:0] exp_en, exp_up, exp_load, exp_done;

    bin_cmd_seq #(.N(8), .CW(16), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_cycles (cmd_cycles),
        .abort      (abort),
        .syn_clr    (syn_clr),
        .load       (load),
        .en         (en),
        .up         (up),
        .d          (d),
        .busy       (busy),
        .done       (done),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] dat, input logic [15:0] cyc);
        cmd_valid  = v;
        cmd_op     = op;
        cmd_data   = dat;
        cmd_cycles = cyc;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_strobes"}, {28'd0, syn_clr, load, en, up}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        abort = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        #2;
        // Reset state
        chk("rst_ready", cmd_ready, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d", d, 0);
        chk_quiet("rst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("post_rst_ready", cmd_ready, 1);

        // COUNT_UP C=12
        drive(1'b1, 3'd1, 8'h00, 16'd12);
        tick();
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        chk("up12_level_after_push", level, 1);
        chk("up12_en_before_pop", en, 0);
        chk("up12_busy_queued", busy, 1);
        tick();
        chk("up12_level_after_pop", level, 0);
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("up12_en_c%0d", k), en, 1);
            chk($sformatf("up12_up_c%0d", k), up, 1);
            chk($sformatf("up12_done_c%0d", k), done, (k == 12) ? 1 : 0);
            chk($sformatf("up12_busy_c%0d", k), busy, 1);
            tick();
        end
        chk("up12_en_after", en, 0);
        chk("up12_up_after", up, 0);
        chk("up12_done_after", done, 0);
        chk("up12_busy_after", busy, 0);

        // Back-to-back COUNT_UP 3, COUNT_DN 2, LOAD 03
        exp_en   = 6'b011111;
        exp_up   = 6'b000111;
        exp_load = 6'b100000;
        exp_done = 6'b110100;
        drive(1'b1, 3'd1, 8'h00, 16'd3);
        tick();
        drive(1'b1, 3'd2, 8'h00, 16'd2);
        tick();
        chk("b2b_en_0", en, exp_en[0]);
        chk("b2b_up_0", up, exp_up[0]);
        chk("b2b_done_0", done, exp_done[0]);
        drive(1'b1, 3'd3, 8'h03, 16'd0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        chk("b2b_level_q", level, 2);
        chk("b2b_d_before_load", d, 8'h00);
        for (int i = 1; i < 6; i++) begin
            if (i > 1) tick();
            chk($sformatf("b2b_en_%0d", i), en, exp_en[i]);
            chk($sformatf("b2b_up_%0d", i), up, exp_up[i]);
            chk($sformatf("b2b_load_%0d", i), load, exp_load[i]);
            chk($sformatf("b2b_done_%0d", i), done, exp_done[i]);
            chk($sformatf("b2b_sclr_%0d", i), syn_clr, 0);
        end
        chk("b2b_d_load", d, 8'h03);
        tick();
        chk_quiet("b2b_end");
        chk("b2b_busy_end", busy, 0);
        chk("b2b_d_hold", d, 8'h03);

        // FIFO fill with WAIT C=100 plus DEPTH more
        drive(1'b1, 3'd5, 8'h00, 16'd100);
        tick();
        chk("fill_level_1", level, 1);
        tick();
        chk("fill_level_pushpop", level, 1);
        chk_quiet("fill_wait");
        tick();
        tick();
        tick();
        chk("fill_level_full", level, 4);
        chk("fill_ready_full", cmd_ready, 0);
        tick();
        chk("fill_level_hold", level, 4);
        chk_quiet("fill_wait2");
        abort = 1'b1;
        #1;
        chk("fill_ready_abort", cmd_ready, 0);
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        tick();
        abort = 1'b0;
        chk("fill_abort_level", level, 0);
        chk("fill_abort_busy", busy, 0);
        chk("fill_abort_done", done, 0);

        // Abort in 4th cycle of COUNT_DN C=10 with 2 queued
        drive(1'b1, 3'd2, 8'h00, 16'd10);
        tick();
        drive(1'b1, 3'd3, 8'h55, 16'd0);
        tick();
        chk("ab_c1_en", en, 1);
        drive(1'b1, 3'd1, 8'h00, 16'd5);
        tick();
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        tick();
        tick();
        chk("ab_c4_en", en, 1);
        chk("ab_c4_up", up, 0);
        chk("ab_c4_level", level, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_en", en, 0);
        chk("ab_level", level, 0);
        chk("ab_done", done, 0);
        chk("ab_busy", busy, 0);
        chk("ab_d", d, 8'h03);
        tick();
        chk("ab_done_later", done, 0);
        chk_quiet("ab_later");

        // NOP, reserved op 6, COUNT_UP C=0
        drive(1'b1, 3'd0, 8'h00, 16'd0);
        tick();
        chk("nop_done_0", done, 0);
        drive(1'b1, 3'd6, 8'h00, 16'd0);
        tick();
        chk("nop_done_1", done, 1);
        chk_quiet("nop_1");
        drive(1'b1, 3'd1, 8'h00, 16'd0);
        tick();
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        chk("nop_done_2", done, 1);
        chk_quiet("nop_2");
        chk("nop_level_2", level, 1);
        tick();
        chk("nop_done_3", done, 1);
        chk_quiet("nop_3");
        chk("nop_busy_3", busy, 0);
        tick();
        chk("nop_done_4", done, 0);
        chk_quiet("nop_4");

        // Reset mid-SCLR, with another command queued
        drive(1'b1, 3'd4, 8'h00, 16'd0);
        tick();
        drive(1'b1, 3'd1, 8'h00, 16'd7);
        tick();
        drive(1'b0, 3'd0, 8'h00, 16'd0);
        chk("sclr_active", syn_clr, 1);
        chk("sclr_done", done, 1);
        chk("sclr_level", level, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_sclr", syn_clr, 0);
        chk("arst_done", done, 0);
        chk("arst_d", d, 0);
        chk("arst_level", level, 0);
        chk("arst_busy", busy, 0);
        chk("arst_ready", cmd_ready, 0);
        chk_quiet("arst");
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rerun_ready", cmd_ready, 1);
        tick();
        chk_quiet("rerun_idle");
        chk("rerun_done", done, 0);
        chk("rerun_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_cmd_seq.md
BIN_CMD_SEQ -- requirements
Module: bin_cmd_seq

Interface
REQ-001 Parameter N, default 8: width of the counter load data d and cmd_data.
REQ-002 Parameter CW, default 16: width of the per-command cycle count.
REQ-003 Parameter DEPTH, default 4: command FIFO entries; power of two, at least 2.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  command accepted on edge when cmd_valid&&cmd_ready.
REQ-008 cmd_op  in  3  0 NOP, 1 COUNT_UP, 2 COUNT_DN, 3 LOAD, 4 SCLR, 5 WAIT, 6-7 reserved.
REQ-009 cmd_data  in  N  load value, used by LOAD only.
REQ-010 cmd_cycles  in  CW  active-cycle count, used by COUNT_UP, COUNT_DN and WAIT.
REQ-011 abort  in  1  synchronous flush of FIFO and current command.
REQ-012 syn_clr, load, en, up  out  1 each  counter control strobes, registered.
REQ-013 d  out  N  counter load data, registered.
REQ-014 busy  out  1  FSM in EXEC or FIFO non-empty.
REQ-015 done  out  1  high during the final active cycle of each completed command.
REQ-016 level  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-017 cmd_ready = (level < DEPTH) && !abort; an accepted command is written to the FIFO tail and is not poppable until the next cycle.
REQ-018 FSM states IDLE and EXEC; IDLE pops the FIFO head on any edge where level > 0.
REQ-019 Popped COUNT_UP/COUNT_DN/WAIT with cmd_cycles = C > 0: outputs active for exactly C cycles, starting the cycle after the pop edge.
REQ-020 Popped LOAD or SCLR: exactly 1 active cycle.
REQ-021 Popped NOP, reserved op, or COUNT/WAIT with C = 0: no strobe asserted, done high for 1 cycle, FSM stays in IDLE.
REQ-022 During active cycles: COUNT_UP drives en=1, up=1; COUNT_DN drives en=1, up=0; LOAD drives load=1, d=cmd_data; SCLR drives syn_clr=1; WAIT drives all strobes 0.
REQ-023 At most one of syn_clr, load, en is high in any cycle; up is 0 whenever en is 0.
REQ-024 d changes only at the start of a LOAD and holds its value otherwise, including through abort.
REQ-025 Remaining-cycle counter is CW bits wide and decrements once per active cycle; C = 2^CW-1 runs the full count without wrap.
REQ-026 On the edge ending the final active cycle: if level > 0, the next command pops with no idle gap (back-to-back); otherwise all strobes go 0 and the FSM returns to IDLE.
REQ-027 A push and a pop on the same edge leave level unchanged; level never exceeds DEPTH or underflows.
REQ-028 abort: on the next edge the FIFO empties, all strobes go 0, the FSM enters IDLE, and done is not asserted for the aborted command; abort overrides a simultaneous push or pop.

Reset
REQ-029 reset low asynchronously clears syn_clr, load, en, up, done, busy, d = 0 and level = 0, and puts the FSM in IDLE.
REQ-030 While reset is low, cmd_ready = 0; cmd_ready = 1 from the first cycle after reset deasserts.
REQ-031 Reset asserted mid-command discards that command and all queued commands; no done is asserted.

Verification
REQ-032 Push COUNT_UP C=12 after reset -> en=up=1 for exactly 12 cycles beginning 2 edges after acceptance; done on 12th cycle; busy falls after.
REQ-033 Push COUNT_UP 3, COUNT_DN 2, LOAD 8'h03 back-to-back -> 6 contiguous active cycles: up=1 for 3, en=1/up=0 for 2, load=1 for 1 with d=8'h03; done 3 times.
REQ-034 Push WAIT C=100 then DEPTH more WAITs -> level reaches DEPTH, cmd_ready=0, extra push ignored, level unchanged.
REQ-035 Assert abort in 4th cycle of COUNT_DN C=10 with 2 queued -> en=0 next cycle, level=0, no done, d unchanged.
REQ-036 Assert reset low mid-SCLR -> syn_clr drops without a clock edge; all outputs at reset values.
REQ-037 Push NOP, op 6, COUNT_UP C=0 -> done one cycle each, no strobe ever high.
